// File: rtl/bit_serial_core.sv
// Bit-serial accumulator processor: 3-bit instructions, WIDTH-bit accumulator,
// one ALU bit per cycle LSB first, with carry flag, busy indicator and HALT.
module bit_serial_core #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_data_instruction,
    input  logic [WIDTH-1:0] i_data_switch,
    input  logic             i_start,
    output logic             o_con_pcincr,
    output logic [WIDTH-1:0] o_data_display,
    output logic             o_carry,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // state is the observable FSM position for checkers bound to this block
    state_t           state;
    logic [2:0]       ir;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic a_bit;
    logic b_bit;
    logic r_bit;
    logic c_next;

    // One-bit ALU; SUB feeds the inverted operand bit with carry preset to 1
    always_comb begin
        a_bit  = acc[0];
        b_bit  = (ir == OP_SUB) ? ~op[0] : op[0];
        c_next = (a_bit & b_bit) | (a_bit & c) | (b_bit & c);
        r_bit  = a_bit;
        case (ir)
            OP_LOAD: r_bit = op[0];
            OP_ADD,
            OP_SUB:  r_bit = a_bit ^ b_bit ^ c;
            OP_AND:  r_bit = a_bit & op[0];
            OP_OR:   r_bit = a_bit | op[0];
            OP_XOR:  r_bit = a_bit ^ op[0];
            default: r_bit = a_bit;
        endcase
    end

    assign o_con_pcincr = (state == DONE);
    assign o_busy       = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            ir             <= OP_LOAD;
            acc            <= '0;
            op             <= '0;
            c              <= 1'b0;
            cnt            <= '0;
            o_data_display <= '0;
            o_carry        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) state <= FETCH;
                end
                FETCH: begin
                    ir    <= i_data_instruction;
                    op    <= i_data_switch;
                    cnt   <= '0;
                    c     <= (i_data_instruction == OP_SUB);
                    state <= (i_data_instruction == OP_HALT) ? IDLE : SHIFT;
                end
                SHIFT: begin
                    acc <= {r_bit, acc[WIDTH-1:1]};
                    op  <= op >> 1;
                    if (ir == OP_ADD || ir == OP_SUB) c <= c_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
                end
                DONE: begin
                    if (ir == OP_ADD || ir == OP_SUB) o_carry <= c;
                    if (ir == OP_OUT) o_data_display <= acc;
                    state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_core.sv
// Directed bench for bit_serial_core: an 8-bit and a 16-bit instance, each fed
// by a small PC-addressed instruction/switch store modelled here.
module tb_bit_serial_core;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8-bit instance and its store
    logic        rst8, start8, pcincr8, carry8, busy8, pc_clr8;
    logic [7:0]  disp8;
    logic [3:0]  pc8;
    logic [2:0]  prog8 [0:15];
    logic [7:0]  sw8   [0:15];
    logic [2:0]  instr8;
    logic [7:0]  swin8;
    assign instr8 = prog8[pc8];
    assign swin8  = sw8[pc8];

    // 16-bit instance and its store
    logic        rst16, start16, pcincr16, carry16, busy16, pc_clr16;
    logic [15:0] disp16;
    logic [3:0]  pc16;
    logic [2:0]  prog16 [0:15];
    logic [15:0] sw16   [0:15];
    logic [2:0]  instr16;
    logic [15:0] swin16;
    assign instr16 = prog16[pc16];
    assign swin16  = sw16[pc16];

    bit_serial_core #(.WIDTH(8)) dut8 (
        .i_clk              (clk),
        .i_rst              (rst8),
        .i_data_instruction (instr8),
        .i_data_switch      (swin8),
        .i_start            (start8),
        .o_con_pcincr       (pcincr8),
        .o_data_display     (disp8),
        .o_carry            (carry8),
        .o_busy             (busy8)
    );

    bit_serial_core #(.WIDTH(16)) dut16 (
        .i_clk              (clk),
        .i_rst              (rst16),
        .i_data_instruction (instr16),
        .i_data_switch      (swin16),
        .i_start            (start16),
        .o_con_pcincr       (pcincr16),
        .o_data_display     (disp16),
        .o_carry            (carry16),
        .o_busy             (busy16)
    );

    always @(posedge clk) begin
        if (pc_clr8) pc8 <= 4'd0;
        else if (pcincr8) pc8 <= pc8 + 4'd1;
        if (pc_clr16) pc16 <= 4'd0;
        else if (pcincr16) pc16 <= pc16 + 4'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_programs();
        for (int i = 0; i < 16; i++) begin
            prog8[i]  = OP_HALT;
            sw8[i]    = 8'h00;
            prog16[i] = OP_HALT;
            sw16[i]   = 16'h0000;
        end
    endtask

    task automatic clear_pc();
        @(negedge clk);
        pc_clr8  = 1'b1;
        pc_clr16 = 1'b1;
        @(negedge clk);
        pc_clr8  = 1'b0;
        pc_clr16 = 1'b0;
    endtask

    // Pulse start for one edge, then sample every negedge (sample n follows
    // edge n after the start edge) until busy drops. Optional extra start
    // pulses are driven while the core is busy.
    task automatic run_prog(input bit wide, input int max_cyc,
                            input int kick_a, input int kick_b,
                            output int n_pulse, output int first_p,
                            output int last_p, output int idle_at);
        n_pulse = 0;
        first_p = -1;
        last_p  = -1;
        idle_at = -1;
        @(negedge clk);
        if (wide) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            if (wide ? pcincr16 : pcincr8) begin
                if (first_p < 0) first_p = n;
                last_p = n;
                n_pulse++;
            end
            if (!(wide ? busy16 : busy8)) begin
                idle_at = n;
                break;
            end
            if (n == kick_a || n == kick_b) begin
                if (wide) start16 = 1'b1; else start8 = 1'b1;
            end else begin
                start8  = 1'b0;
                start16 = 1'b0;
            end
            @(negedge clk);
        end
        start8  = 1'b0;
        start16 = 1'b0;
        n_checks++;
        if (idle_at < 0) begin
            $display("FAIL run_timeout: busy still %0d after %0d cycles, required 0",
                     wide ? busy16 : busy8, max_cyc);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst8  = 1'b1;
        rst16 = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, pcincr8, carry8, disp8} !== 11'd0) begin
            $display("FAIL reset8: busy/pcincr/carry/display=%b, required all 0",
                     {busy8, pcincr8, carry8, disp8});
            n_fail++;
        end
        n_checks++;
        if ({busy16, pcincr16, carry16, disp16} !== 19'd0) begin
            $display("FAIL reset16: busy/pcincr/carry/display=%b, required all 0",
                     {busy16, pcincr16, carry16, disp16});
            n_fail++;
        end
        rst8  = 1'b0;
        rst16 = 1'b0;
    endtask

    task automatic test_load_out_halt();
        int np, fp, lp, ia;
        clear_programs();
        prog8[0] = OP_LOAD; sw8[0] = 8'hF0;
        prog8[1] = OP_OUT;
        prog8[2] = OP_HALT;
        clear_pc();
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (np !== 2 || fp !== 9 || lp !== 19) begin
            $display("FAIL loh_pulses: count=%0d first=%0d last=%0d, required 2/9/19", np, fp, lp);
            n_fail++;
        end
        n_checks++;
        if (ia !== 21) begin
            $display("FAIL loh_busy_fall: idle at sample %0d, required 21", ia);
            n_fail++;
        end
        n_checks++;
        if (disp8 !== 8'hF0) begin
            $display("FAIL loh_display: got %h, required f0", disp8);
            n_fail++;
        end
        n_checks++;
        if (pc8 !== 4'd2) begin
            $display("FAIL loh_pc: got %0d, required 2", pc8);
            n_fail++;
        end
    endtask

    task automatic test_add();
        int np, fp, lp, ia;
        clear_programs();
        prog8[0] = OP_LOAD; sw8[0] = 8'hF0;
        prog8[1] = OP_ADD;  sw8[1] = 8'h20;
        prog8[2] = OP_OUT;
        clear_pc();
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (disp8 !== 8'h10 || carry8 !== 1'b1) begin
            $display("FAIL add_overflow: display=%h carry=%b, required 10/1", disp8, carry8);
            n_fail++;
        end
        prog8[0] = OP_LOAD; sw8[0] = 8'h01;
        prog8[1] = OP_ADD;  sw8[1] = 8'h01;
        clear_pc();
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (disp8 !== 8'h02 || carry8 !== 1'b0) begin
            $display("FAIL add_small: display=%h carry=%b, required 02/0", disp8, carry8);
            n_fail++;
        end
    endtask

    task automatic test_sub();
        int np, fp, lp, ia;
        clear_programs();
        prog8[0] = OP_LOAD; sw8[0] = 8'h05;
        prog8[1] = OP_SUB;  sw8[1] = 8'h07;
        prog8[2] = OP_OUT;
        clear_pc();
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (disp8 !== 8'hFE || carry8 !== 1'b0) begin
            $display("FAIL sub_borrow: display=%h carry=%b, required fe/0", disp8, carry8);
            n_fail++;
        end
        prog8[0] = OP_LOAD; sw8[0] = 8'h07;
        prog8[1] = OP_SUB;  sw8[1] = 8'h05;
        clear_pc();
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (disp8 !== 8'h02 || carry8 !== 1'b1) begin
            $display("FAIL sub_noborrow: display=%h carry=%b, required 02/1", disp8, carry8);
            n_fail++;
        end
    endtask

    // Carry is 1 on entry and must survive every logic op; the accumulator
    // carries over from one HALTed program to the next restart.
    task automatic test_logic();
        int np, fp, lp, ia;
        clear_programs();
        prog8[0] = OP_LOAD; sw8[0] = 8'hCC;
        prog8[1] = OP_AND;  sw8[1] = 8'hAA;
        prog8[2] = OP_OUT;
        clear_pc();
        run_prog(1'b0, 200, 4, 14, np, fp, lp, ia);
        n_checks++;
        if (np !== 3 || lp !== 29 || ia !== 31) begin
            $display("FAIL logic_start_ignored: pulses=%0d last=%0d idle=%0d, required 3/29/31",
                     np, lp, ia);
            n_fail++;
        end
        n_checks++;
        if (disp8 !== 8'h88 || carry8 !== 1'b1) begin
            $display("FAIL logic_and: display=%h carry=%b, required 88/1", disp8, carry8);
            n_fail++;
        end
        clear_programs();
        prog8[0] = OP_OR; sw8[0] = 8'h11;
        prog8[1] = OP_OUT;
        clear_pc();
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (disp8 !== 8'h99 || carry8 !== 1'b1) begin
            $display("FAIL logic_or: display=%h carry=%b, required 99/1", disp8, carry8);
            n_fail++;
        end
        prog8[0] = OP_XOR; sw8[0] = 8'hFF;
        clear_pc();
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (disp8 !== 8'h66 || carry8 !== 1'b1) begin
            $display("FAIL logic_xor: display=%h carry=%b, required 66/1", disp8, carry8);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_shift();
        int np, fp, lp, ia;
        clear_programs();
        prog8[0] = OP_LOAD; sw8[0] = 8'h81;
        prog8[1] = OP_OUT;
        prog8[2] = OP_ADD;  sw8[2] = 8'h80;
        prog8[3] = OP_OUT;
        clear_pc();
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (23) @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b1 || disp8 !== 8'h81) begin
            $display("FAIL rst_pre: busy=%b display=%h, required 1/81", busy8, disp8);
            n_fail++;
        end
        rst8 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy8, pcincr8, carry8, disp8} !== 11'd0) begin
            $display("FAIL rst_mid_shift: busy/pcincr/carry/display=%b, required all 0",
                     {busy8, pcincr8, carry8, disp8});
            n_fail++;
        end
        @(negedge clk);
        rst8 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b0 || pc8 !== 4'd2) begin
            $display("FAIL rst_hold: busy=%b pc=%0d, required 0/2", busy8, pc8);
            n_fail++;
        end
        run_prog(1'b0, 200, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (disp8 !== 8'h80 || carry8 !== 1'b0 || pc8 !== 4'd4 || np !== 2) begin
            $display("FAIL rst_resume: display=%h carry=%b pc=%0d pulses=%0d, required 80/0/4/2",
                     disp8, carry8, pc8, np);
            n_fail++;
        end
    endtask

    task automatic test_width16();
        int np, fp, lp, ia;
        clear_programs();
        prog16[0] = OP_LOAD; sw16[0] = 16'hFFFF;
        prog16[1] = OP_ADD;  sw16[1] = 16'h0001;
        prog16[2] = OP_OUT;
        clear_pc();
        run_prog(1'b1, 400, -1, -1, np, fp, lp, ia);
        n_checks++;
        if (np !== 3 || fp !== 17 || lp !== 53 || ia !== 55) begin
            $display("FAIL w16_period: pulses=%0d first=%0d last=%0d idle=%0d, required 3/17/53/55",
                     np, fp, lp, ia);
            n_fail++;
        end
        n_checks++;
        if (disp16 !== 16'h0000 || carry16 !== 1'b1) begin
            $display("FAIL w16_add: display=%h carry=%b, required 0000/1", disp16, carry16);
            n_fail++;
        end
    endtask

    initial begin
        rst8     = 1'b1;
        rst16    = 1'b1;
        start8   = 1'b0;
        start16  = 1'b0;
        pc_clr8  = 1'b1;
        pc_clr16 = 1'b1;
        clear_programs();
        test_reset();
        test_load_out_halt();
        test_add();
        test_sub();
        test_logic();
        test_reset_mid_shift();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
